rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write requesters sharing the register-file write port (2..4).
REQ-002 Parameter CNT_W, default 16: width of the conflict counter.
REQ-003 Ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Ports: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: req_valid  in  NUM_REQ  per-requester write request.
REQ-006 Ports: req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on valid&ready.
REQ-007 Ports: req_reg  in  NUM_REQ*5  flattened destination indices; requester i occupies bits [5i+4:5i].
REQ-008 Ports: req_data  in  NUM_REQ*32  flattened write data; requester i occupies bits [32i+31:32i].
REQ-009 Ports: wrtEn / wrtReg / wrtData  out  1/5/32  registered write port driving the register file.
REQ-010 Ports: grant_id  out  2  index of the requester whose write is on wrtReg/wrtData.
REQ-011 Ports: conflict_cnt  out  CNT_W  saturating count of contended cycles.
REQ-012 Ports: rdReg1, rdReg2  in  5 each; fwd_hit1, fwd_hit2  out  1 each; fwd_data1, fwd_data2  out  32 each: read-port forwarding.

Function
REQ-013 req_ready SHALL be combinational and one-hot among the asserted req_valid bits, or zero when none are valid.
REQ-014 Selection SHALL be round-robin, searching upward from pointer ptr with wrap-around past NUM_REQ-1 to 0.
REQ-015 After a grant to requester i, ptr SHALL become (i+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-016 No backpressure: every granted transfer is accepted in its handshake cycle.
REQ-017 Latency 1: on the edge ending a transfer, wrtEn=1, wrtReg=req_reg[i], wrtData=req_data[i], grant_id=i, each held for exactly one cycle.
REQ-018 With no transfer, wrtEn SHALL be 0, and wrtReg/wrtData/grant_id SHALL hold their previous values.
REQ-019 A transfer targeting register 0 SHALL complete the handshake (ready asserted, ptr advanced) but SHALL leave wrtEn=0.
REQ-020 Requesters hold valid, reg and data stable until ready; a non-granted requester retains priority order for the next cycle.
REQ-021 conflict_cnt SHALL increment by 1 on each cycle with two or more req_valid bits set, and SHALL saturate at all-ones.
REQ-022 A single requester held continuously valid SHALL be granted every cycle, giving back-to-back wrtEn pulses.

Reset
REQ-023 While rst=1: wrtEn=0, wrtReg=0, wrtData=0, grant_id=0, conflict_cnt=0, ptr=0, req_ready=0, and fwd_hit*=0.
REQ-024 A request presented during a reset cycle SHALL NOT be granted; a write registered before reset SHALL be cleared at the reset edge.
REQ-025 In the first cycle after rst falls, arbitration SHALL start from requester 0.

Configuration
REQ-026 With macro RF_ARB_FWD_EN defined: fwd_hitN = wrtEn & (wrtReg==rdRegN) & (rdRegN!=0), combinationally.
REQ-027 With RF_ARB_FWD_EN defined: fwd_dataN = wrtData when fwd_hitN=1, else 0.
REQ-028 Without RF_ARB_FWD_EN: the forwarding ports remain present, fwd_hit*/fwd_data* are tied to 0, and rdReg* are ignored.

Structure
REQ-029 Package rf_arb_pkg SHALL hold REG_ADDR_W=5, XLEN=32 and the NUM_REQ default.
REQ-030 Round-robin selection SHALL be one combinational sub-module, rf_rr_pick, with inputs valid and ptr and a one-hot grant output.

Verification
REQ-031 Single requester: req_valid=001, reg=5, data=0xFF -> ready=001 the same cycle; next cycle wrtEn=1, wrtReg=5, wrtData=0xFF, grant_id=0.
REQ-032 Contention: all three valid for 3 cycles from reset -> grants 0,1,2 in order, and conflict_cnt reaches 3 (NUM_REQ=3).
REQ-033 x0 write: requester 1 writes reg 0, data 0x45 -> ready asserted, wrtEn stays 0, and the next grant goes to requester 2.
REQ-034 Reset mid-stream: rst=1 in the cycle after a grant -> wrtEn=0, conflict_cnt=0, and the next arbitration starts at requester 0.
REQ-035 Forwarding (RF_ARB_FWD_EN): pending write reg 14 = 0x1234 with rdReg1=14, rdReg2=10 -> fwd_hit1=1, fwd_data1=0x1234, fwd_hit2=0.
REQ-036 Saturation with CNT_W=2: 5 contended cycles -> conflict_cnt holds at 3.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter.
package rf_arb_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;
  localparam int NUM_REQ_DEF = 3;
  localparam int GID_W       = 2;
endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping from NUM_REQ-1 back to 0. Produces a one-hot grant.
module rf_rr_pick
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GID_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found_s;

  // Scan offsets 0..NUM_REQ-1 from ptr; the first valid slot wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && valid[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
          grant[j] = 1'b1;
          found_s  = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ requesters.
// Optional write-to-read forwarding is enabled by defining RF_ARB_FWD_EN.
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic                          wrtEn,
  output logic [REG_ADDR_W-1:0]         wrtReg,
  output logic [XLEN-1:0]               wrtData,
  output logic [GID_W-1:0]              grant_id,
  output logic [CNT_W-1:0]              conflict_cnt,
  input  logic [REG_ADDR_W-1:0]         rdReg1,
  input  logic [REG_ADDR_W-1:0]         rdReg2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [XLEN-1:0]               fwd_data1,
  output logic [XLEN-1:0]               fwd_data2
);

  logic [NUM_REQ-1:0]    grant_s;
  logic                  any_grant_s;
  logic                  contended_s;
  logic [GID_W-1:0]      gid_s;
  logic [REG_ADDR_W-1:0] sel_reg_s;
  logic [XLEN-1:0]       sel_data_s;

  logic [GID_W-1:0]      ptr_q,      ptr_d;
  logic                  wrt_en_q,   wrt_en_d;
  logic [REG_ADDR_W-1:0] wrt_reg_q,  wrt_reg_d;
  logic [XLEN-1:0]       wrt_data_q, wrt_data_d;
  logic [GID_W-1:0]      gid_q,      gid_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  rf_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant_s)
  );

  // No grant may be issued while reset is held.
  assign req_ready   = rst ? '0 : grant_s;
  assign any_grant_s = |req_ready;
  assign contended_s = ($countones(req_valid) >= 2);

  // Mux out the granted requester's index, register and data.
  always_comb begin
    gid_s      = '0;
    sel_reg_s  = '0;
    sel_data_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready[j]) begin
        gid_s      = GID_W'(j);
        sel_reg_s  = req_reg[j*REG_ADDR_W +: REG_ADDR_W];
        sel_data_s = req_data[j*XLEN +: XLEN];
      end else begin
        gid_s = gid_s;
      end
    end
  end

  // Next-state: pointer advance, write-port capture and conflict counting.
  always_comb begin
    ptr_d      = ptr_q;
    wrt_en_d   = 1'b0;
    wrt_reg_d  = wrt_reg_q;
    wrt_data_d = wrt_data_q;
    gid_d      = gid_q;
    cnt_d      = cnt_q;
    if (any_grant_s) begin
      if (gid_s == GID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gid_s + 2'd1;
      end
      // A transfer to x0 completes the handshake but never writes.
      wrt_en_d   = (sel_reg_s != 5'd0);
      wrt_reg_d  = sel_reg_s;
      wrt_data_d = sel_data_s;
      gid_d      = gid_s;
    end else begin
      ptr_d = ptr_q;
    end
    if (contended_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      wrt_en_q   <= 1'b0;
      wrt_reg_q  <= '0;
      wrt_data_q <= '0;
      gid_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wrt_en_q   <= wrt_en_d;
      wrt_reg_q  <= wrt_reg_d;
      wrt_data_q <= wrt_data_d;
      gid_q      <= gid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wrtEn        = wrt_en_q;
  assign wrtReg       = wrt_reg_q;
  assign wrtData      = wrt_data_q;
  assign grant_id     = gid_q;
  assign conflict_cnt = cnt_q;

`ifdef RF_ARB_FWD_EN
  assign fwd_hit1  = !rst && wrt_en_q && (wrt_reg_q == rdReg1) && (rdReg1 != 5'd0);
  assign fwd_hit2  = !rst && wrt_en_q && (wrt_reg_q == rdReg2) && (rdReg2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? wrt_data_q : 32'd0;
  assign fwd_data2 = fwd_hit2 ? wrt_data_q : 32'd0;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^{rdReg1, rdReg2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = 32'd0;
  assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed + randomized bench for rf_wr_arbiter against a round-robin reference model.
module tb_rf_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [4:0]  rdReg1, rdReg2;

  logic [2:0]  req_ready;
  logic        wrtEn;
  logic [4:0]  wrtReg;
  logic [31:0] wrtData;
  logic [1:0]  grant_id;
  logic [15:0] conflict_cnt;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  logic [2:0]  s_ready;
  logic        s_en;
  logic [4:0]  s_reg;
  logic [31:0] s_data;
  logic [1:0]  s_gid;
  logic [1:0]  s_cnt;
  logic        s_hit1, s_hit2;
  logic [31:0] s_fd1, s_fd2;

  int checks = 0;
  int failures = 0;

  int          m_ptr;
  bit          m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_gid;
  int          m_cnt;
  int          m_cnt_sat;

  always #5 clk = ~clk;

  rf_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .wrtEn(wrtEn), .wrtReg(wrtReg),
    .wrtData(wrtData), .grant_id(grant_id), .conflict_cnt(conflict_cnt),
    .rdReg1(rdReg1), .rdReg2(rdReg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  rf_wr_arbiter #(.NUM_REQ(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready),
    .req_reg(req_reg), .req_data(req_data), .wrtEn(s_en), .wrtReg(s_reg),
    .wrtData(s_data), .grant_id(s_gid), .conflict_cnt(s_cnt),
    .rdReg1(rdReg1), .rdReg2(rdReg2), .fwd_hit1(s_hit1), .fwd_hit2(s_hit2),
    .fwd_data1(s_fd1), .fwd_data2(s_fd2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid requester scanning upward from p with wrap-around.
  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic step(input bit r, input logic [2:0] v, input logic [14:0] rg,
                      input logic [95:0] d, input logic [4:0] r1, input logic [4:0] r2);
    int g;
    logic [2:0] er;
    bit e1, e2;
    logic [31:0] ed1, ed2;
    rst = r; req_valid = v; req_reg = rg; req_data = d; rdReg1 = r1; rdReg2 = r2;
    #2;
    g  = r ? -1 : pick(v, m_ptr);
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("ready", {61'd0, req_ready}, {61'd0, er});
    chk("ready_sat", {61'd0, s_ready}, {61'd0, er});
    @(posedge clk);
    #1;
    if (r) begin
      m_ptr = 0; m_en = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_gid = 0;
      m_cnt = 0; m_cnt_sat = 0;
    end else begin
      if (g >= 0) begin
        m_reg  = rg[g*5 +: 5];
        m_data = d[g*32 +: 32];
        m_en   = (m_reg != 5'd0);
        m_gid  = g;
        m_ptr  = (g + 1) % 3;
      end else begin
        m_en = 1'b0;
      end
      if ($countones(v) >= 2) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
    end
`ifdef RF_ARB_FWD_EN
    e1  = m_en && (m_reg == r1) && (r1 != 5'd0);
    e2  = m_en && (m_reg == r2) && (r2 != 5'd0);
    ed1 = e1 ? m_data : 32'd0;
    ed2 = e2 ? m_data : 32'd0;
`else
    e1 = 1'b0; e2 = 1'b0; ed1 = 32'd0; ed2 = 32'd0;
`endif
    chk("wrtEn", {63'd0, wrtEn}, {63'd0, m_en});
    chk("wrtReg", {59'd0, wrtReg}, {59'd0, m_reg});
    chk("wrtData", {32'd0, wrtData}, {32'd0, m_data});
    chk("grant_id", {62'd0, grant_id}, 64'(m_gid));
    chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cnt));
    chk("conflict_cnt_sat", {62'd0, s_cnt}, 64'(m_cnt_sat));
    chk("wrtEn_sat", {63'd0, s_en}, {63'd0, m_en});
    chk("fwd_hit1", {63'd0, fwd_hit1}, {63'd0, e1});
    chk("fwd_hit2", {63'd0, fwd_hit2}, {63'd0, e2});
    chk("fwd_data1", {32'd0, fwd_data1}, {32'd0, ed1});
    chk("fwd_data2", {32'd0, fwd_data2}, {32'd0, ed2});
  endtask

  initial begin
    logic [14:0] rr;
    logic [95:0] rd;
    logic [4:0]  q1, q2;
    m_ptr = 0; m_en = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_gid = 0; m_cnt = 0; m_cnt_sat = 0;
    rst = 1'b1; req_valid = 3'b000; req_reg = 15'd0; req_data = 96'd0; rdReg1 = 5'd0; rdReg2 = 5'd0;

    // Reset state, including a request offered during reset.
    step(1'b1, 3'b000, 15'd0, 96'd0, 5'd0, 5'd0);
    step(1'b1, 3'b111, 15'h7FFF, {96{1'b1}}, 5'd31, 5'd31);
    chk("rst_cnt", {48'd0, conflict_cnt}, 64'd0);

    // Single requester: reg 5, data 0xFF.
    step(1'b0, 3'b001, {10'd0, 5'd5}, {64'd0, 32'hFF}, 5'd0, 5'd0);
    chk("single_en", {63'd0, wrtEn}, 64'd1);
    chk("single_reg", {59'd0, wrtReg}, 64'd5);
    chk("single_data", {32'd0, wrtData}, 64'hFF);

    // Contention from reset: grants 0,1,2 in order.
    step(1'b1, 3'b000, 15'd0, 96'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 5'd0, 5'd0);
      chk("contend_gid", {62'd0, grant_id}, 64'(i));
    end
    chk("contend_cnt", {48'd0, conflict_cnt}, 64'd3);

    // x0 write by requester 1: handshake completes, no write, pointer moves to 2.
    step(1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h45, 32'd0}, 5'd0, 5'd0);
    chk("x0_en", {63'd0, wrtEn}, 64'd0);
    step(1'b0, 3'b111, {5'd9, 5'd8, 5'd7}, {32'h3, 32'h2, 32'h1}, 5'd0, 5'd0);
    chk("x0_next_gid", {62'd0, grant_id}, 64'd2);

    // Single requester held valid: back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b100, {5'd7, 10'd0}, {32'(i + 100), 64'd0}, 5'd0, 5'd0);
      chk("b2b_en", {63'd0, wrtEn}, 64'd1);
    end

    // Reset mid-stream.
    step(1'b0, 3'b010, {5'd0, 5'd4, 5'd0}, {32'd0, 32'h44, 32'd0}, 5'd0, 5'd0);
    step(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 5'd0, 5'd0);
    chk("midrst_en", {63'd0, wrtEn}, 64'd0);
    chk("midrst_cnt", {48'd0, conflict_cnt}, 64'd0);
    step(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 5'd0, 5'd0);
    chk("midrst_gid", {62'd0, grant_id}, 64'd0);

    // Forwarding of pending write reg 14 = 0x1234.
    step(1'b0, 3'b001, {10'd0, 5'd14}, {64'd0, 32'h1234}, 5'd14, 5'd10);
`ifdef RF_ARB_FWD_EN
    chk("fwd_dir_hit1", {63'd0, fwd_hit1}, 64'd1);
    chk("fwd_dir_data1", {32'd0, fwd_data1}, 64'h1234);
`else
    chk("fwd_dir_hit1", {63'd0, fwd_hit1}, 64'd0);
    chk("fwd_dir_data1", {32'd0, fwd_data1}, 64'd0);
`endif
    chk("fwd_dir_hit2", {63'd0, fwd_hit2}, 64'd0);

    // Saturation of the 2-bit counter after 5 contended cycles.
    step(1'b1, 3'b000, 15'd0, 96'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b011, {5'd0, 5'd12, 5'd11}, {32'd0, 32'h22, 32'h11}, 5'd0, 5'd0);
    end
    chk("sat_cnt", {62'd0, s_cnt}, 64'd3);
    chk("wide_cnt", {48'd0, conflict_cnt}, 64'd5);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rr = 15'($urandom);
      rd = {$urandom, $urandom, $urandom};
      q1 = ($urandom_range(0, 1) == 0) ? m_reg : 5'($urandom);
      q2 = ($urandom_range(0, 3) == 0) ? m_reg : 5'($urandom);
      step($urandom_range(0, 39) == 0, 3'($urandom_range(0, 7)), rr, rd, q1, q2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
